// File: rtl/hidden_pkg.sv
// Shared constants and FSM state encoding for the hidden-layer MAC scheduler.
// The optional HIDDEN_SAT_EN build macro is consumed by hidden_mac_acc.
package hidden_pkg;

    localparam int N_FEAT   = 81;
    localparam int XW       = 7;
    localparam int AW       = 32;
    localparam int BIAS_ONE = 65536;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/hidden_mac_acc.sv
// Multiply / load / accumulate datapath for one hidden-unit inner product.
// Define HIDDEN_SAT_EN to saturate each accumulation instead of wrapping.
module hidden_mac_acc #(
    parameter int XW = hidden_pkg::XW,
    parameter int AW = hidden_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          term_v,
    input  logic          term_k0,
    input  logic [XW-1:0] px_data,
    input  logic [AW-1:0] th_data,
    output logic [AW-1:0] acc
);
    import hidden_pkg::*;

    logic [AW-1:0] prod;
    logic [AW-1:0] bias_term;
    logic [AW-1:0] acc_nxt;

    // Both products keep only the low AW bits, matching two's-complement wrap.
    assign prod      = th_data * {{(AW-XW){1'b0}}, px_data};
    assign bias_term = th_data * AW'(BIAS_ONE);

`ifdef HIDDEN_SAT_EN
    logic [AW:0] wide;

    assign wide = {acc[AW-1], acc} + {prod[AW-1], prod};

    always_comb begin
        acc_nxt = wide[AW-1:0];
        if (wide[AW] != wide[AW-1])
            acc_nxt = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`else
    assign acc_nxt = acc + prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (term_v)
            acc <= term_k0 ? bias_term : acc_nxt;
    end

endmodule

// File: rtl/hidden_mac_sched.sv
// Sequences theta/pixel reads for each hidden unit and presents results over
// a valid/ready port. Build option HIDDEN_SAT_EN selects saturating accumulation.
module hidden_mac_sched #(
    parameter int N_FEAT  = hidden_pkg::N_FEAT,
    parameter int N_UNITS = 10,
    parameter int XW      = hidden_pkg::XW,
    parameter int AW      = hidden_pkg::AW,
    localparam int UW     = $clog2(N_UNITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [6:0]    px_addr,
    input  logic [XW-1:0] px_data,
    output logic [UW+6:0] th_addr,
    input  logic [AW-1:0] th_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic [UW-1:0] res_unit
);
    import hidden_pkg::*;

    localparam logic [6:0]    LAST_IDX  = 7'(N_FEAT - 1);
    localparam logic [UW-1:0] LAST_UNIT = UW'(N_UNITS - 1);

    state_t        state;
    logic [6:0]    idx;
    logic [UW-1:0] unit;
    logic          term_v;
    logic          term_k0;
    logic          hs;
    logic [AW-1:0] acc;

    // Result port: res_valid is held in OUT until res_ready; a transfer
    // happens on the rising edge where both are high.
    assign hs = (state == OUT) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            unit    <= '0;
            term_v  <= 1'b0;
            term_k0 <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the
            // accumulate strobes trail the MAC issue cycle by one.
            term_v  <= (state == MAC);
            term_k0 <= (state == MAC) && (idx == '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        unit  <= '0;
                        idx   <= '0;
                    end
                end
                MAC: begin
                    idx <= idx + 7'd1;
                    if (idx == LAST_IDX)
                        state <= DRAIN;
                end
                DRAIN: state <= OUT;
                OUT: begin
                    if (res_ready) begin
                        if (unit != LAST_UNIT) begin
                            unit  <= unit + 1'b1;
                            idx   <= '0;
                            state <= MAC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = hs && (unit == LAST_UNIT);
    assign px_addr   = (state == MAC) ? idx : '0;
    assign th_addr   = (state == MAC) ? {unit, idx} : '0;
    assign res_valid = (state == OUT);
    assign res_data  = acc;
    assign res_unit  = unit;

    hidden_mac_acc #(
        .XW(XW),
        .AW(AW)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .term_v  (term_v),
        .term_k0 (term_k0),
        .px_data (px_data),
        .th_data (th_data),
        .acc     (acc)
    );

endmodule

// File: tb/tb_hidden_mac_sched.sv
// Directed bench for hidden_mac_sched with behavioural pixel and theta memories.
module tb_hidden_mac_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [6:0]  px_addr;
    logic [6:0]  px_data;
    logic [10:0] th_addr;
    logic [31:0] th_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_unit;

    logic [6:0]  pix_mem [128];
    logic [31:0] th_mem  [2048];

    logic [31:0] exp_q  [$];
    logic [31:0] res_q  [$];
    logic [3:0]  unit_q [$];

    int checks;
    int passes;

    hidden_mac_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .px_addr   (px_addr),
        .px_data   (px_data),
        .th_addr   (th_addr),
        .th_data   (th_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_unit  (res_unit)
    );

    // clock / memories
    always #5 clk = ~clk;

    always @(posedge clk) begin
        px_data <= pix_mem[px_addr];
        th_data <= th_mem[th_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [6:0] p, input logic [31:0] t0, input logic [31:0] tk);
        for (int i = 0; i < 128; i++) pix_mem[i] = p;
        for (int a = 0; a < 2048; a++) th_mem[a] = (a % 128 == 0) ? t0 : tk;
    endtask

    function automatic logic [31:0] ref_dot(input int u);
        logic [31:0] a;
        logic [31:0] p;
        logic signed [33:0] s;
        a = th_mem[u*128] * 32'd65536;
        for (int k = 1; k < 81; k++) begin
            p = th_mem[u*128+k] * {25'd0, pix_mem[k]};
`ifdef HIDDEN_SAT_EN
            s = {{2{a[31]}}, a} + {{2{p[31]}}, p};
            if (s > 34'sd2147483647)       a = 32'h7fffffff;
            else if (s < -34'sd2147483648) a = 32'h80000000;
            else                           a = s[31:0];
`else
            a = a + p;
`endif
        end
        return a;
    endfunction

    // Driver: one full run; t counts edges from the one that samples start (t=1).
    task automatic run_full(input int pulse_at, input bit start_on_done,
                            input int hold_unit, input int hold_len,
                            output int first_v, output int done_t,
                            output int unstable, output int hs_t, output int next_t);
        int t;
        bit held;
        logic [31:0] sd;
        logic [3:0]  su;
        first_v = 0; done_t = 0; unstable = 0; hs_t = 0; next_t = 0;
        held = 0; t = 0;
        res_q.delete();
        unit_q.delete();
        res_ready = 1'b1;
        start = 1'b1;
        while (t < 1500 && done_t == 0) begin
            tick();
            t++;
            start = (t + 1 == pulse_at);
            if (res_valid === 1'b1 && first_v == 0) first_v = t;
            if (hold_len > 0 && !held && res_valid === 1'b1 && res_unit === 4'(hold_unit)) begin
                held = 1;
                sd = res_data;
                su = res_unit;
                res_ready = 1'b0;
                repeat (hold_len) begin
                    tick();
                    t++;
                    if (res_valid !== 1'b1 || res_data !== sd || res_unit !== su) unstable++;
                end
                res_ready = 1'b1;
                hs_t = t;
            end
            if (hs_t != 0 && next_t == 0 && t > hs_t && th_addr === 11'd512) next_t = t;
            if (res_valid === 1'b1) begin
                res_q.push_back(res_data);
                unit_q.push_back(res_unit);
            end
            if (done === 1'b1) begin
                done_t = t;
                if (start_on_done) start = 1'b1;
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else passes++;
        checks++; if (px_addr !== 7'd0) $display("FAIL reset_px_addr: got %0h want 0", px_addr); else passes++;
        checks++; if (th_addr !== 11'd0) $display("FAIL reset_th_addr: got %0h want 0", th_addr); else passes++;
        checks++; if (res_data !== 32'd0) $display("FAIL reset_res_data: got %0h want 0", res_data); else passes++;
        checks++; if (res_unit !== 4'd0) $display("FAIL reset_res_unit: got %0h want 0", res_unit); else passes++;
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bias_run;
        int fv, dt, un, hs, nx, bad;
        fill(7'd0, 32'd1, 32'd5);
        exp_q.delete();
        for (int u = 0; u < 10; u++) exp_q.push_back(32'd65536);
        run_full(0, 0, -1, 0, fv, dt, un, hs, nx);
        checks++; if (fv !== 83) $display("FAIL bias_first_valid: got %0d want 83", fv); else passes++;
        checks++; if (dt !== 830) $display("FAIL bias_done_cycle: got %0d want 830", dt); else passes++;
        checks++; if (res_q.size() !== 10) $display("FAIL bias_count: got %0d want 10", res_q.size()); else passes++;
        bad = 0;
        for (int i = 0; i < res_q.size() && i < 10; i++) begin
            if (res_q[i] !== exp_q[i]) bad++;
            if (unit_q[i] !== 4'(i)) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bias_results: got %0d bad want 0", bad); else passes++;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bias_idle_after: got %0d bad want 0", bad); else passes++;
    endtask

    task automatic test_ones_and_neg;
        int fv, dt, un, hs, nx, bad;
        fill(7'd1, 32'd1, 32'd1);
        run_full(0, 0, -1, 0, fv, dt, un, hs, nx);
        bad = 0;
        for (int i = 0; i < res_q.size(); i++) if (res_q[i] !== 32'd65616) bad++;
        checks++; if (bad !== 0 || res_q.size() !== 10)
            $display("FAIL ones_result: got %0d (%0d bad of %0d) want 65616", res_q.size() > 0 ? res_q[0] : 0, bad, res_q.size());
        else passes++;
        fill(7'd127, 32'd0, 32'hffffffff);
        run_full(0, 0, -1, 0, fv, dt, un, hs, nx);
        bad = 0;
        for (int i = 0; i < res_q.size(); i++) if (res_q[i] !== 32'hffffd850) bad++;
        checks++; if (bad !== 0 || res_q.size() !== 10)
            $display("FAIL neg_result: got %0h (%0d bad of %0d) want ffffd850", res_q.size() > 0 ? res_q[0] : 0, bad, res_q.size());
        else passes++;
        checks++; if (dt !== 830) $display("FAIL neg_done_cycle: got %0d want 830", dt); else passes++;
    endtask

    task automatic test_backpressure;
        int fv, dt, un, hs, nx, bad;
        fill(7'd1, 32'd1, 32'd1);
        run_full(0, 0, 3, 20, fv, dt, un, hs, nx);
        checks++; if (un !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", un); else passes++;
        checks++; if (hs == 0 || nx !== hs + 1) $display("FAIL bp_unit4_start: got %0d want %0d", nx, hs + 1); else passes++;
        checks++; if (dt !== 850) $display("FAIL bp_done_cycle: got %0d want 850", dt); else passes++;
        bad = 0;
        for (int i = 0; i < res_q.size(); i++) if (res_q[i] !== 32'd65616 || unit_q[i] !== 4'(i)) bad++;
        checks++; if (bad !== 0 || res_q.size() !== 10)
            $display("FAIL bp_results: got %0d bad of %0d want 0 of 10", bad, res_q.size());
        else passes++;
    endtask

    task automatic test_start_ignored;
        int fv, dt, un, hs, nx, bad;
        fill(7'd1, 32'd1, 32'd1);
        run_full(40, 1, -1, 0, fv, dt, un, hs, nx);
        checks++; if (dt !== 830) $display("FAIL ign_done_cycle: got %0d want 830", dt); else passes++;
        bad = 0;
        for (int i = 0; i < res_q.size(); i++) if (unit_q[i] !== 4'(i)) bad++;
        checks++; if (bad !== 0 || res_q.size() !== 10)
            $display("FAIL ign_unit_order: got %0d bad of %0d want 0 of 10", bad, res_q.size());
        else passes++;
        bad = 0;
        repeat (5) begin
            if (busy !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) $display("FAIL ign_busy_after_done: got %0d busy cycles want 0", bad); else passes++;
    endtask

    task automatic test_reset_mid_run;
        int fv, dt, un, hs, nx, bad;
        bit found;
        fill(7'd1, 32'd1, 32'd1);
        found = 0;
        start = 1'b1;
        res_ready = 1'b1;
        for (int t = 0; t < 700 && !found; t++) begin
            tick();
            start = 1'b0;
            if (th_addr === 11'd650) found = 1;
        end
        checks++; if (!found) $display("FAIL rst_reach_unit5: got timeout want th_addr 650"); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, res_valid} !== 3'b000)
            $display("FAIL rst_mid_flags: got %b want 000", {busy, done, res_valid});
        else passes++;
        checks++; if ({px_addr, th_addr, res_data, res_unit} !== 54'd0)
            $display("FAIL rst_mid_values: got px %0h th %0h d %0h u %0h want 0", px_addr, th_addr, res_data, res_unit);
        else passes++;
        bad = 0;
        repeat (3) begin
            tick();
            if (res_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d events want 0", bad); else passes++;
        rst_n = 1'b1;
        tick();
        run_full(0, 0, -1, 0, fv, dt, un, hs, nx);
        checks++; if (unit_q.size() == 0 || unit_q[0] !== 4'd0)
            $display("FAIL rst_restart_unit: got %0d want 0", unit_q.size() > 0 ? unit_q[0] : 4'hf);
        else passes++;
        checks++; if (res_q.size() == 0 || res_q[0] !== 32'd65616)
            $display("FAIL rst_restart_data: got %0d want 65616", res_q.size() > 0 ? res_q[0] : 0);
        else passes++;
        checks++; if (dt !== 830) $display("FAIL rst_restart_done: got %0d want 830", dt); else passes++;
    endtask

    task automatic test_saturation;
        int fv, dt, un, hs, nx;
        logic [31:0] want;
        fill(7'd127, 32'd32767, 32'h01000000);
`ifdef HIDDEN_SAT_EN
        want = 32'h7fffffff;
`else
        want = 32'd805240832;
`endif
        run_full(0, 0, -1, 0, fv, dt, un, hs, nx);
        checks++; if (res_q.size() !== 10) $display("FAIL sat_count: got %0d want 10", res_q.size()); else passes++;
        checks++; if (res_q.size() == 0 || res_q[0] !== want)
            $display("FAIL sat_value: got %0h want %0h", res_q.size() > 0 ? res_q[0] : 0, want);
        else passes++;
        checks++; if (res_q.size() < 10 || res_q[9] !== ref_dot(9))
            $display("FAIL sat_model: got %0h want %0h", res_q.size() >= 10 ? res_q[9] : 0, ref_dot(9));
        else passes++;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        res_ready = 1'b0;
        checks = 0;
        passes = 0;
        fill(7'd0, 32'd0, 32'd0);
        test_reset();
        test_bias_run();
        test_ones_and_neg();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
